// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: oversampled start validation, 5..8 data bits LSB-first,
// optional parity, one or two stop bits, error flags and an idle-line timeout.
//
// state        | meaning
// S_IDLE       | line idle, waiting for a low sample on a baud_tick
// S_START      | timing to start-bit middle, rejects glitches
// S_DATA       | sampling data bits, one per bit period
// S_PARITY     | sampling and checking the parity bit
// S_STOP_0     | sampling first stop bit
// S_STOP_1     | sampling second stop bit
// S_BREAK_WAIT | last stop bit was low, waiting for line to return high
module uart_rx_sequencer #(
   parameter int OVERSAMPLE   = 16,
   parameter int TIMEOUT_BITS = 32,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       baud_tick,
   input  logic       rxd,
   input  logic       rx_en,
   input  logic [3:0] data_bits,
   input  logic       parity_en,
   input  logic       parity_odd,
   input  logic       stop_bit_twice,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       timeout_flag,
   output logic       rx_busy
);

   localparam int TW       = $clog2(OVERSAMPLE);
   localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
   localparam int OW       = $clog2(TO_TICKS);
   localparam logic [TW-1:0] MID_LD = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LD = TW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0] TO_LD  = OW'(TO_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP_0,
      S_STOP_1,
      S_BREAK_WAIT
   } state_t;

   state_t              r_state;
   state_t              r_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [TW-1:0]       r_tick_cnt;
   logic [2:0]          r_bit_cnt;
   logic [7:0]          r_shift;
   logic                r_par_acc;
   logic                r_perr;
   logic [3:0]          r_n;
   logic                r_par_en;
   logic                r_par_odd;
   logic                r_two_stop;
   logic [7:0]          r_rx_data;
   logic                r_rx_valid;
   logic                r_parity_err;
   logic                r_frame_err;
   logic                r_timeout;
   logic                r_to_armed;
   logic [OW-1:0]       r_to_cnt;

   logic                w_rxd;
   logic                w_tick_tc;
   logic                w_start_det;
   logic                w_start_ok;
   logic                w_complete;
   logic [3:0]          w_clamp_n;
   logic [3:0]          w_rjust_sh;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_sync <= '1;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
   end

   assign w_rxd       = r_sync[SYNC_STAGES-1];
   assign w_tick_tc   = baud_tick && (r_tick_cnt == '0);
   assign w_start_det = (r_state == S_IDLE) && rx_en && baud_tick && !w_rxd;
   assign w_start_ok  = (r_state == S_START) && rx_en && w_tick_tc && !w_rxd;
   assign w_rjust_sh  = 4'd8 - r_n;

   always_comb begin
      w_clamp_n = data_bits;
      if (data_bits < 4'd5)      w_clamp_n = 4'd5;
      else if (data_bits > 4'd8) w_clamp_n = 4'd8;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_state <= S_IDLE;
      else          r_state <= r_state_nxt;
   end

   always_comb begin
      r_state_nxt = r_state;
      w_complete  = 1'b0;
      if (!rx_en) begin
         r_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (w_start_det) r_state_nxt = S_START;
            S_START:  if (w_tick_tc) r_state_nxt = w_rxd ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick_tc && (r_bit_cnt == '0))
                         r_state_nxt = r_par_en ? S_PARITY : S_STOP_0;
            S_PARITY: if (w_tick_tc) r_state_nxt = S_STOP_0;
            S_STOP_0: if (w_tick_tc) begin
                         if (r_two_stop && w_rxd) begin
                            r_state_nxt = S_STOP_1;
                         end else begin
                            w_complete  = 1'b1;
                            r_state_nxt = w_rxd ? S_IDLE : S_BREAK_WAIT;
                         end
                      end
            S_STOP_1: if (w_tick_tc) begin
                         w_complete  = 1'b1;
                         r_state_nxt = w_rxd ? S_IDLE : S_BREAK_WAIT;
                      end
            S_BREAK_WAIT: if (w_rxd) r_state_nxt = S_IDLE;
            default:  r_state_nxt = S_IDLE;
         endcase
      end
   end

   // Tick timer counts down to the next sample point: half a bit first, then whole bits.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_tick_cnt <= '0;
      end else if (!rx_en || (r_state == S_BREAK_WAIT)) begin
         r_tick_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_tick_cnt <= w_start_det ? MID_LD : '0;
      end else if (baud_tick) begin
         r_tick_cnt <= (r_tick_cnt == '0) ? BIT_LD : r_tick_cnt - 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_par_acc  <= 1'b0;
         r_perr     <= 1'b0;
         r_n        <= 4'd8;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_two_stop <= 1'b0;
      end else if (w_start_ok) begin
         r_n        <= w_clamp_n;
         r_par_en   <= parity_en;
         r_par_odd  <= parity_odd;
         r_two_stop <= stop_bit_twice;
         r_bit_cnt  <= 3'(w_clamp_n - 4'd1);
         r_shift    <= '0;
         r_par_acc  <= 1'b0;
         r_perr     <= 1'b0;
      end else if ((r_state == S_DATA) && w_tick_tc) begin
         r_shift   <= {w_rxd, r_shift[7:1]};
         r_par_acc <= r_par_acc ^ w_rxd;
         if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - 1'b1;
      end else if ((r_state == S_PARITY) && w_tick_tc) begin
         r_perr <= r_par_acc ^ w_rxd ^ r_par_odd;
      end
   end

   // Data enters at the MSB, so short frames are shifted down on delivery.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rx_valid   <= 1'b0;
         r_rx_data    <= '0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_rx_valid <= w_complete;
         if (w_complete) begin
            r_rx_data    <= r_shift >> w_rjust_sh;
            r_parity_err <= r_par_en & r_perr;
            r_frame_err  <= !w_rxd;
         end
      end
   end

   // Completion happens outside IDLE, so the reload there keeps timeout off rx_valid cycles.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_to_armed <= 1'b0;
         r_to_cnt   <= '0;
         r_timeout  <= 1'b0;
      end else if (!rx_en) begin
         r_to_armed <= 1'b0;
         r_to_cnt   <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         if (w_complete) begin
            r_to_armed <= 1'b1;
            r_to_cnt   <= TO_LD;
         end else if (r_to_armed && (r_state == S_IDLE)) begin
            if (w_start_det) begin
               r_to_cnt <= TO_LD;
            end else if (baud_tick && w_rxd) begin
               if (r_to_cnt == '0) begin
                  r_timeout  <= 1'b1;
                  r_to_armed <= 1'b0;
               end else begin
                  r_to_cnt <= r_to_cnt - 1'b1;
               end
            end
         end
      end
   end

   assign rx_data      = r_rx_data;
   assign rx_valid     = r_rx_valid;
   assign parity_err   = r_parity_err;
   assign frame_err    = r_frame_err;
   assign timeout_flag = r_timeout;
   assign rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer: frames are serialised onto rxd, expected
// results queued at send time and compared when rx_valid pulses.
module tb_uart_rx_sequencer;

   localparam int BIT_CYC = 64;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       baud_tick = 1'b0;
   logic       rxd = 1'b1;
   logic       rx_en = 1'b0;
   logic [3:0] data_bits = 4'd8;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       stop_bit_twice = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       timeout_flag;
   logic       rx_busy;

   uart_rx_sequencer #(.OVERSAMPLE(16), .TIMEOUT_BITS(32), .SYNC_STAGES(2)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .baud_tick(baud_tick), .rxd(rxd), .rx_en(rx_en),
      .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd),
      .stop_bit_twice(stop_bit_twice), .rx_data(rx_data), .rx_valid(rx_valid),
      .parity_err(parity_err), .frame_err(frame_err), .timeout_flag(timeout_flag),
      .rx_busy(rx_busy)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_valid = 0;
   int   n_to = 0;
   int   ticks_since = 0;
   int   last_to_ticks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   initial begin
      forever begin
         repeat (3) @(posedge PCLK);
         #1 baud_tick = 1'b1;
         @(posedge PCLK);
         #1 baud_tick = 1'b0;
      end
   end

   always @(negedge PCLK) begin
      if (rx_valid) begin
         n_valid++;
         ticks_since = 0;
         if (sb_q.size() == 0) begin
            chk("unexpected_valid", rx_valid, 0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("rx_data", rx_data, mon_e.d);
            chk("parity_err", parity_err, mon_e.pe);
            chk("frame_err", frame_err, mon_e.fe);
         end
      end else if (baud_tick) begin
         ticks_since++;
      end
      if (timeout_flag) begin
         n_to++;
         last_to_ticks = ticks_since;
         chk("timeout_with_valid", rx_valid, 0);
      end
   end

   task automatic send_bit(input logic b);
      @(posedge PCLK);
      #1 rxd = b;
      repeat (BIT_CYC - 1) @(posedge PCLK);
   endtask

   task automatic idle_bits(input int n);
      @(posedge PCLK);
      #1 rxd = 1'b1;
      repeat (n * BIT_CYC) @(posedge PCLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                             input logic pbit, input logic two, input logic s1, input logic s2);
      logic [7:0] dm;
      exp_t       e;
      dm   = d & 8'((1 << nb) - 1);
      e.d  = dm;
      e.pe = pen && (pbit != ((^dm) ^ parity_odd));
      e.fe = two ? (!s1 || !s2) : !s1;
      sb_q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(dm[i]);
      if (pen) send_bit(pbit);
      send_bit(s1);
      if (two) send_bit(s2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      int bc;
      repeat (5) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_valid", rx_valid, 0);
      chk("rst_busy", rx_busy, 0);
      chk("rst_timeout", timeout_flag, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_ferr", frame_err, 0);
      @(posedge PCLK);
      #1 PRESETn = 1'b1;
      rx_en = 1'b1;
      idle_bits(2);

      // 8N1 0xA5
      data_bits = 4'd8; parity_en = 1'b0; stop_bit_twice = 1'b0;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle_bits(2);

      // 7E1 and 7O1, 0x41 with parity bit 1
      data_bits = 4'd7; parity_en = 1'b1; parity_odd = 1'b0;
      send_frame(8'h41, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      idle_bits(2);
      parity_odd = 1'b1;
      send_frame(8'h41, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      idle_bits(2);

      // start glitch of 4 ticks
      v0 = n_valid;
      bc = 0;
      @(posedge PCLK);
      #1 rxd = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge PCLK);
         #1 if (i == 15) rxd = 1'b1;
         @(negedge PCLK);
         if (rx_busy) bc++;
      end
      chk("glitch_busy_seen", (bc > 0) ? 1 : 0, 1);
      chk("glitch_busy_short", (bc <= 33) ? 1 : 0, 1);
      chk("glitch_no_valid", n_valid, v0);
      idle_bits(2);

      // 5N2 (data_bits clamps up), second stop low, then break
      data_bits = 4'd2; parity_en = 1'b0; parity_odd = 1'b0; stop_bit_twice = 1'b1;
      send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (3 * BIT_CYC) @(posedge PCLK);
      @(negedge PCLK);
      chk("break_wait_busy", rx_busy, 1);
      @(posedge PCLK);
      #1 rxd = 1'b1;
      repeat (8) @(posedge PCLK);
      @(negedge PCLK);
      chk("break_exit_idle", rx_busy, 0);
      idle_bits(1);
      send_frame(8'h03, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle_bits(2);

      // rx_en dropped after 3 data bits
      data_bits = 4'd8; stop_bit_twice = 1'b0;
      v0 = n_valid;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(negedge PCLK);
      chk("busy_before_drop", rx_busy, 1);
      @(posedge PCLK);
      #1 rx_en = 1'b0;
      rxd = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      chk("busy_after_drop", rx_busy, 0);
      idle_bits(12);
      chk("drop_no_valid", n_valid, v0);
      rx_en = 1'b1;
      data_bits = 4'd15;
      idle_bits(1);
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // idle timeout after a frame, no repeat, re-armed by next frame
      for (int i = 0; i < 3000 && n_to == 0; i++) @(posedge PCLK);
      @(negedge PCLK);
      chk("timeout_first", n_to, 1);
      chk("timeout_ticks_1", last_to_ticks, 512);
      repeat (700 * 4) @(posedge PCLK);
      chk("timeout_no_repeat", n_to, 1);
      data_bits = 4'd8;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3000 && n_to < 2; i++) @(posedge PCLK);
      @(negedge PCLK);
      chk("timeout_rearmed", n_to, 2);
      chk("timeout_ticks_2", last_to_ticks, 512);

      // async reset in the middle of a frame
      v0 = n_valid;
      send_bit(1'b0);
      send_bit(1'b1);
      #3 PRESETn = 1'b0;
      #1;
      chk("midreset_busy", rx_busy, 0);
      chk("midreset_valid", rx_valid, 0);
      rxd = 1'b1;
      @(posedge PCLK);
      #1 PRESETn = 1'b1;
      idle_bits(12);
      chk("midreset_no_valid", n_valid, v0);

      chk("sb_empty", sb_q.size(), 0);
      chk("valid_total", n_valid, 7);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
